// File: rtl/tm1638_driver.sv
// TM1638 frame sequencer: turns one latched segment/LED frame into the 18-word
// FIFO write stream (mode, 8 x {segment, LED}, display on), stalling on FIFO full.

package tm1638_types;
    typedef logic [7:0][7:0] segments_t;
    typedef logic [7:0]      leds_t;
endpackage

package tm1638_driver_types;
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SET_MODE   = 3'd1,
        WRITE_SEG  = 3'd2,
        WRITE_LED  = 3'd3,
        DISPLAY_ON = 3'd4
    } state_t;
    typedef logic [2:0] grid_t;
endpackage

module tm1638_driver
    import tm1638_types::*;
    import tm1638_driver_types::*;
(
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [63:0] i_Segments,
    input  logic [7:0]  i_Leds,
    input  logic        i_Valid,
    input  logic        i_SPI_FIFO_Full,
    output logic [16:0] o_Data,
    output logic        o_Write,
    output logic [2:0]  o_Diag_State,
    output logic [2:0]  o_Diag_Grid,
    output logic [63:0] o_Diag_Segments,
    output logic [7:0]  o_Diag_Leds
);

    state_t    state_q;
    grid_t     grid_q;
    segments_t segments_q;
    leds_t     leds_q;

    logic       write;
    logic [7:0] seg_addr;
    logic [7:0] led_addr;

    assign write    = (state_q != IDLE) && !i_SPI_FIFO_Full;
    // Grid addresses are even for segments and odd for LEDs, so OR-ing is exact.
    assign seg_addr = 8'hC0 | {4'b0000, grid_q, 1'b0};
    assign led_addr = seg_addr | 8'h01;

    always_comb begin
        o_Data = 17'd0;
        case (state_q)
            SET_MODE:   o_Data = {1'b0, 8'h00, 8'h44};
            WRITE_SEG:  o_Data = {1'b1, seg_addr, segments_q[grid_q]};
            WRITE_LED:  o_Data = {1'b1, led_addr, 7'b0000000, leds_q[grid_q]};
            DISPLAY_ON: o_Data = {1'b0, 8'h00, 8'h8F};
            default:    o_Data = 17'd0;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q    <= IDLE;
            grid_q     <= '0;
            segments_q <= '0;
            leds_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_Valid) begin
                        segments_q <= i_Segments;
                        leds_q     <= i_Leds;
                        grid_q     <= '0;
                        state_q    <= SET_MODE;
                    end
                end
                SET_MODE: begin
                    if (write) state_q <= WRITE_SEG;
                end
                WRITE_SEG: begin
                    if (write) state_q <= WRITE_LED;
                end
                WRITE_LED: begin
                    if (write) begin
                        if (grid_q == 3'd7) begin
                            state_q <= DISPLAY_ON;
                        end else begin
                            grid_q  <= grid_q + 3'd1;
                            state_q <= WRITE_SEG;
                        end
                    end
                end
                DISPLAY_ON: begin
                    if (write) begin
                        state_q <= IDLE;
                        grid_q  <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grid_q  <= '0;
                end
            endcase
        end
    end

    assign o_Write         = write;
    assign o_Diag_State    = state_q;
    assign o_Diag_Grid     = grid_q;
    assign o_Diag_Segments = segments_q;
    assign o_Diag_Leds     = leds_q;

endmodule

// File: tb/tb_tm1638_driver.sv
// Bench for tm1638_driver: expected word streams come from a frame-level model
// (list of 18 words built from the frame contents) compared against FIFO writes.
module tb_tm1638_driver;

    logic        clk;
    logic        rst_n;
    logic [63:0] seg_in;
    logic [7:0]  led_in;
    logic        valid;
    logic        full;
    logic [16:0] o_data;
    logic        o_write;
    logic [2:0]  diag_state;
    logic [2:0]  diag_grid;
    logic [63:0] diag_segs;
    logic [7:0]  diag_leds;

    int n_cmp = 0;
    int n_bad = 0;
    logic [16:0] exp_q[$];

    tm1638_driver dut (
        .i_Clk          (clk),
        .i_Rst          (rst_n),
        .i_Segments     (seg_in),
        .i_Leds         (led_in),
        .i_Valid        (valid),
        .i_SPI_FIFO_Full(full),
        .o_Data         (o_data),
        .o_Write        (o_write),
        .o_Diag_State   (diag_state),
        .o_Diag_Grid    (diag_grid),
        .o_Diag_Segments(diag_segs),
        .o_Diag_Leds    (diag_leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame model: mode command, then per grid a segment word and an LED word, then display on.
    task automatic push_frame(input logic [63:0] s, input logic [7:0] l);
        exp_q.push_back(17'h00044);
        for (int g = 0; g < 8; g++) begin
            exp_q.push_back({1'b1, 8'(8'hC0 + 2 * g), s[8*g +: 8]});
            exp_q.push_back({1'b1, 8'(8'hC1 + 2 * g), 7'b0, l[g]});
        end
        exp_q.push_back(17'h0008F);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; valid = 1'b0; full = 1'b0; seg_in = '0; led_in = '0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (o_write !== 1'b0) begin n_bad++; $display("FAIL reset_write: got %b want 0", o_write); end
        n_cmp++; if (o_data !== 17'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", o_data); end
        n_cmp++; if (diag_state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", diag_state); end
        n_cmp++; if (diag_grid !== 3'd0) begin n_bad++; $display("FAIL reset_grid: got %0d want 0", diag_grid); end
        n_cmp++; if (diag_segs !== 64'd0) begin n_bad++; $display("FAIL reset_segs: got %h want 0", diag_segs); end
        n_cmp++; if (diag_leds !== 8'd0) begin n_bad++; $display("FAIL reset_leds: got %h want 0", diag_leds); end
        valid = 1'b1; seg_in = 64'hFFFF_0000_1234_5678;
        @(posedge clk); #1;
        n_cmp++; if (diag_state !== 3'd0) begin n_bad++; $display("FAIL reset_hold_valid: state got %0d want 0", diag_state); end
        valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (o_write !== 1'b0) begin n_bad++; $display("FAIL reset_release_idle: write got %b want 0", o_write); end
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_basic_frame();
        logic [63:0] s;
        logic [16:0] obs[18];
        int n;
        for (int g = 0; g < 8; g++) s[8*g +: 8] = 8'(8'h10 + g);
        seg_in = s; led_in = 8'hA5; valid = 1'b1;
        exp_q.delete(); push_frame(s, 8'hA5);
        @(posedge clk); #1; valid = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (o_write !== 1'b1 || o_data !== exp_q[0]) begin
                n_bad++; $display("FAIL basic_word%0d: got wr=%b data=%h want wr=1 data=%h", n + 1, o_write, o_data, exp_q[0]);
            end
            obs[n] = o_data; n++;
            void'(exp_q.pop_front());
            @(posedge clk); #1;
        end
        n_cmp++; if (obs[1] !== 17'h1C010) begin n_bad++; $display("FAIL basic_anchor2: got %h want 1c010", obs[1]); end
        n_cmp++; if (obs[2] !== 17'h1C101) begin n_bad++; $display("FAIL basic_anchor3: got %h want 1c101", obs[2]); end
        n_cmp++; if (obs[4] !== 17'h1C300) begin n_bad++; $display("FAIL basic_anchor5: got %h want 1c300", obs[4]); end
        n_cmp++; if (obs[17] !== 17'h0008F) begin n_bad++; $display("FAIL basic_anchor18: got %h want 0008f", obs[17]); end
        @(negedge clk);
        n_cmp++; if (o_write !== 1'b0 || diag_state !== 3'd0) begin n_bad++; $display("FAIL basic_end_idle: got wr=%b state=%0d want wr=0 state=0", o_write, diag_state); end
        n_cmp++; if (diag_segs !== s || diag_leds !== 8'hA5) begin n_bad++; $display("FAIL basic_diag_frame: got %h/%h want %h/a5", diag_segs, diag_leds, s); end
        @(posedge clk); #1;
        $display("test_basic_frame done");
    endtask

    task automatic test_stall();
        logic [63:0] s;
        int idx, stalls;
        for (int g = 0; g < 8; g++) s[8*g +: 8] = 8'(8'h10 + g);
        seg_in = s; led_in = 8'hA5; valid = 1'b1;
        exp_q.delete(); push_frame(s, 8'hA5);
        @(posedge clk); #1; valid = 1'b0;
        idx = 0; stalls = 0;
        for (int cyc = 0; cyc < 60 && idx < 18; cyc++) begin
            full = (idx == 8 && stalls < 5);
            if (full) stalls++;
            @(negedge clk);
            if (full) begin
                n_cmp++;
                if (o_write !== 1'b0 || o_data !== 17'h1C700) begin
                    n_bad++; $display("FAIL stall_hold%0d: got wr=%b data=%h want wr=0 data=1c700", stalls, o_write, o_data);
                end
            end else begin
                n_cmp++;
                if (o_write !== 1'b1 || o_data !== exp_q[idx]) begin
                    n_bad++; $display("FAIL stall_word%0d: got wr=%b data=%h want wr=1 data=%h", idx + 1, o_write, o_data, exp_q[idx]);
                end
                idx++;
            end
            @(posedge clk); #1;
        end
        full = 1'b0;
        n_cmp++; if (idx != 18 || stalls != 5) begin n_bad++; $display("FAIL stall_count: got words=%0d stalls=%0d want 18/5", idx, stalls); end
        @(negedge clk);
        n_cmp++; if (diag_state !== 3'd0) begin n_bad++; $display("FAIL stall_end_idle: got state=%0d want 0", diag_state); end
        @(posedge clk); #1;
        $display("test_stall done");
    endtask

    task automatic test_revalid();
        logic [63:0] s;
        logic [7:0] l;
        int idx;
        s = {$urandom, $urandom}; l = 8'($urandom);
        seg_in = s; led_in = l; valid = 1'b1;
        exp_q.delete(); push_frame(s, l);
        @(posedge clk); #1; valid = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 40 && idx < 18; cyc++) begin
            valid = (idx == 5);
            if (idx == 5) begin seg_in = ~s; led_in = ~l; end
            @(negedge clk);
            n_cmp++;
            if (o_write !== 1'b1 || o_data !== exp_q[idx]) begin
                n_bad++; $display("FAIL revalid_word%0d: got wr=%b data=%h want wr=1 data=%h", idx + 1, o_write, o_data, exp_q[idx]);
            end
            idx++;
            @(posedge clk); #1;
        end
        valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (diag_segs !== s || diag_leds !== l) begin n_bad++; $display("FAIL revalid_diag: got %h/%h want %h/%h", diag_segs, diag_leds, s, l); end
        n_cmp++; if (o_write !== 1'b0 || diag_state !== 3'd0) begin n_bad++; $display("FAIL revalid_end_idle: got wr=%b state=%0d want 0/0", o_write, diag_state); end
        @(posedge clk); #1;
        $display("test_revalid done");
    endtask

    task automatic test_reset_midframe();
        logic [63:0] s;
        int idx;
        s = {$urandom, $urandom};
        seg_in = s; led_in = 8'($urandom); valid = 1'b1;
        @(posedge clk); #1; valid = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 20 && idx < 9; cyc++) begin
            @(negedge clk); idx++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++; if (diag_state !== 3'd2 || diag_grid !== 3'd4) begin n_bad++; $display("FAIL midreset_pre: got state=%0d grid=%0d want 2/4", diag_state, diag_grid); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (diag_state !== 3'd0 || o_write !== 1'b0) begin n_bad++; $display("FAIL midreset_async: got state=%0d wr=%b want 0/0", diag_state, o_write); end
        n_cmp++; if (diag_grid !== 3'd0 || diag_segs !== 64'd0 || o_data !== 17'd0) begin n_bad++; $display("FAIL midreset_regs: got grid=%0d segs=%h data=%h want 0", diag_grid, diag_segs, o_data); end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++; if (o_write !== 1'b0 || diag_state !== 3'd0) begin n_bad++; $display("FAIL midreset_wait%0d: got wr=%b state=%0d want 0/0", k, o_write, diag_state); end
        end
        @(posedge clk); #1;
        $display("test_reset_midframe done");
    endtask

    task automatic test_random();
        int hold, frames;
        exp_q.delete();
        hold = $urandom_range(2, 12); frames = 0; full = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (--hold == 0) begin full = ~full; hold = $urandom_range(2, 12); end
            valid = ($urandom_range(0, 9) == 0);
            seg_in = {$urandom, $urandom}; led_in = 8'($urandom);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_cmp++; if (o_write !== 1'b0 || o_data !== 17'd0) begin n_bad++; $display("FAIL rand_idle_c%0d: got wr=%b data=%h want 0/0", cyc, o_write, o_data); end
                if (valid) begin push_frame(seg_in, led_in); frames++; end
            end else if (full) begin
                n_cmp++; if (o_write !== 1'b0 || o_data !== exp_q[0]) begin n_bad++; $display("FAIL rand_stall_c%0d: got wr=%b data=%h want wr=0 data=%h", cyc, o_write, o_data, exp_q[0]); end
            end else begin
                n_cmp++; if (o_write !== 1'b1 || o_data !== exp_q[0]) begin n_bad++; $display("FAIL rand_word_c%0d: got wr=%b data=%h want wr=1 data=%h", cyc, o_write, o_data, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            @(posedge clk); #1;
        end
        valid = 1'b0; full = 1'b0;
        for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            n_cmp++; if (o_write !== 1'b1 || o_data !== exp_q[0]) begin n_bad++; $display("FAIL rand_drain: got wr=%b data=%h want wr=1 data=%h", o_write, o_data, exp_q[0]); end
            void'(exp_q.pop_front());
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++; if (o_write !== 1'b0 || diag_state !== 3'd0) begin n_bad++; $display("FAIL rand_end_idle: got wr=%b state=%0d want 0/0", o_write, diag_state); end
        @(posedge clk); #1;
        $display("test_random done: %0d frames", frames);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_stall();
        test_revalid();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tm1638_driver.md
TM1638_DRIVER -- requirements
Module: tm1638_driver

Interface
REQ-001 Types: segments_t = packed [7:0][7:0] (byte g = segments of grid g) and leds_t = [7:0] (bit g = LED g), from tm1638_types; state_t = 3-bit enum and grid_t = [2:0], from tm1638_driver_types.
REQ-002 i_Clk  input  1  single clock; all state changes on rising edge.
REQ-003 i_Rst  input  1  reset, asynchronous and active-low.
REQ-004 i_Segments  input  64 (segments_t)  segment pattern for grids 0..7.
REQ-005 i_Leds  input  8 (leds_t)  LED states, bit g = LED g.
REQ-006 i_Valid  input  1  request a display frame update using current i_Segments/i_Leds.
REQ-007 i_SPI_FIFO_Full  input  1  downstream SPI FIFO full; no write may be issued while high.
REQ-008 o_Data  output  17  FIFO word: [16] = two-byte flag, [15:8] = first byte (address), [7:0] = data/command byte.
REQ-009 o_Write  output  1  FIFO write strobe; one word accepted per cycle high.
REQ-010 o_Diag_State  output  3 (state_t)  current FSM state.
REQ-011 o_Diag_Grid  output  3 (grid_t)  current grid index.
REQ-012 o_Diag_Segments  output  64  latched segment frame.
REQ-013 o_Diag_Leds  output  8  latched LED frame.

Function
REQ-014 States: IDLE=0, SET_MODE=1, WRITE_SEG=2, WRITE_LED=3, DISPLAY_ON=4; codes 5-7 unused and go to IDLE on the next clock.
REQ-015 IDLE: o_Write=0, o_Data=0; when i_Valid=1 at a clock edge, latch i_Segments/i_Leds into the frame registers, set grid=0, go to SET_MODE.
REQ-016 i_Valid is ignored in every state other than IDLE; frame registers are unchanged until the next IDLE acceptance.
REQ-017 o_Write = (state != IDLE) AND NOT i_SPI_FIFO_Full, combinational from the current state and full; o_Data is combinational from state/grid/frame.
REQ-018 The FSM advances only on an edge where o_Write=1; while full=1, state, grid, and o_Data hold.
REQ-019 SET_MODE: o_Data = {0, 8'h00, 8'h44} (fixed-address data command); advance to WRITE_SEG.
REQ-020 WRITE_SEG: o_Data = {1, 8'hC0 + 2*grid, segments[grid]}; advance to WRITE_LED.
REQ-021 WRITE_LED: o_Data = {1, 8'hC1 + 2*grid, 7'b0, leds[grid]}; if grid=7, go to DISPLAY_ON, else grid+1 and go to WRITE_SEG.
REQ-022 DISPLAY_ON: o_Data = {0, 8'h00, 8'h8F} (display on, max brightness); advance to IDLE with grid=0.
REQ-023 Frame = exactly 18 writes in order: 44, C0/seg0, C1/led0, C2/seg1, ..., CE/seg7, CF/led7, 8F.
REQ-024 With full held low, a frame takes 18 consecutive o_Write cycles starting the cycle after i_Valid is accepted; the FSM returns to IDLE on the 19th edge.
REQ-025 Full toggling at any point only inserts stall cycles; no word is dropped, duplicated, or reordered.
REQ-026 Diag outputs are direct copies of the internal state, grid, and frame registers.

Reset
REQ-027 While i_Rst=0 (asynchronously): state=IDLE, grid=0, frame segments=0, frame LEDs=0, so o_Write=0 and o_Data=0.
REQ-028 Reset mid-frame aborts the frame; after release the driver waits in IDLE for a new i_Valid.

Verification
REQ-029 Reset then i_Valid with segments byte g = 8'h10+g, leds=8'hA5, full=0 -> 18 consecutive writes, e.g. word 2 = 1_C0_10, word 3 = 1_C1_01, word 5 = 1_C3_00, word 18 = 0_00_8F.
REQ-030 Same frame with full forced high for 5 cycles during WRITE_LED grid 3 -> o_Write=0 and o_Data stays 1_C7_00 for those cycles; the sequence resumes unchanged.
REQ-031 i_Valid pulsed again mid-frame with new data -> the current frame completes with the old data; Diag_Segments is unchanged.
REQ-032 Reset asserted while in WRITE_SEG grid 4 -> Diag_State=0, o_Write=0 immediately, without waiting for a clock edge.
REQ-033 Random full toggling every 2-12 cycles over 2000 cycles with i_Valid pulsing -> every frame's write stream exactly matches REQ-023, and no write occurs while full=1.
